// File: rtl/cv32e41s_pkg.sv
// Shared types for the multiplier issue slice: operator encoding, issue FSM states and RV32M funct3 codes.
package cv32e41s_pkg;

  typedef enum logic [0:0] {
    MUL_M32 = 1'b0,
    MUL_H   = 1'b1
  } mul_opcode_e;

  typedef enum logic [1:0] {
    MUL_ISSUE_IDLE = 2'd0,
    MUL_ISSUE_EXEC = 2'd1,
    MUL_ISSUE_WB   = 2'd2
  } mul_issue_state_e;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

  // Only funct3 0..3 are multiplies; 4..7 (divide/remainder) are not handled here.
  function automatic logic funct3_is_mul(input logic [2:0] funct3);
    return !funct3[2];
  endfunction

endpackage

// File: rtl/cv32e41s_mult_decode.sv
// Combinational funct3 decoder: multiplier operator, operand signedness and illegal flag.
module cv32e41s_mult_decode
  import cv32e41s_pkg::*;
(
  input  logic [2:0]  funct3_i,
  output mul_opcode_e operator_o,
  output logic [1:0]  signed_mode_o,
  output logic        illegal_o
);

  always_comb begin
    operator_o    = MUL_M32;
    signed_mode_o = '0;
    illegal_o     = 1'b0;
    case (funct3_i)
      FUNCT3_MUL: begin
        operator_o    = MUL_M32;
        signed_mode_o = 2'b00;
      end
      FUNCT3_MULH: begin
        operator_o    = MUL_H;
        signed_mode_o = 2'b11;
      end
      FUNCT3_MULHSU: begin
        operator_o    = MUL_H;
        signed_mode_o = 2'b01;
      end
      FUNCT3_MULHU: begin
        operator_o    = MUL_H;
        signed_mode_o = 2'b00;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cv32e41s_mult_issue.sv
// Multiplier issue stage: ID handshake, operand hold during EXEC, registered writeback slot, kill flush.
// Optional macro CV32E41S_MULT_ZERO_SHORTCUT_EN: zero operand bypasses the multiplier straight to WB.
module cv32e41s_mult_issue
  import cv32e41s_pkg::*;
#(
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill_i,

  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [2:0]      id_funct3_i,
  input  logic [31:0]     id_op_a_i,
  input  logic [31:0]     id_op_b_i,
  input  logic [RD_W-1:0] id_rd_i,

  output logic            mul_valid_o,
  output mul_opcode_e     mul_operator_o,
  output logic [1:0]      mul_signed_mode_o,
  output logic [31:0]     mul_op_a_o,
  output logic [31:0]     mul_op_b_o,
  input  logic [31:0]     mul_result_i,
  input  logic            mul_valid_i,
  output logic            mul_ready_o,
  input  logic            mul_ready_i,

  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [31:0]     wb_result_o,
  output logic [RD_W-1:0] wb_rd_o
);

  mul_issue_state_e state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [31:0]      result_q, result_d;
  logic [RD_W-1:0]  rd_q, rd_d;

  logic             dec_illegal;
  logic             accept;
  logic             zero_op;
  logic             unused_mul_ready;

  cv32e41s_mult_decode u_decode (
    .funct3_i      (funct3_q),
    .operator_o    (mul_operator_o),
    .signed_mode_o (mul_signed_mode_o),
    .illegal_o     (dec_illegal)
  );

`ifdef CV32E41S_MULT_ZERO_SHORTCUT_EN
  assign zero_op = (id_op_a_i == '0) || (id_op_b_i == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The result handshake completes on mul_valid_i alone; multiplier ready is not needed.
  assign unused_mul_ready = mul_ready_i;

  assign id_ready_o  = !kill_i && ((state_q == MUL_ISSUE_IDLE) ||
                                   ((state_q == MUL_ISSUE_WB) && wb_ready_i));
  assign mul_valid_o = !kill_i && (state_q == MUL_ISSUE_EXEC) && !dec_illegal;
  assign mul_ready_o = (state_q == MUL_ISSUE_EXEC);
  assign wb_valid_o  = !kill_i && (state_q == MUL_ISSUE_WB);
  assign mul_op_a_o  = op_a_q;
  assign mul_op_b_o  = op_b_q;
  assign wb_result_o = result_q;
  assign wb_rd_o     = rd_q;

  assign accept = id_valid_i && id_ready_o;

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    rd_d     = rd_q;

    if (kill_i) begin
      state_d = MUL_ISSUE_IDLE;
    end else begin
      case (state_q)
        MUL_ISSUE_IDLE: ;
        MUL_ISSUE_EXEC: begin
          if (mul_valid_i) begin
            result_d = mul_result_i;
            state_d  = MUL_ISSUE_WB;
          end
        end
        MUL_ISSUE_WB: begin
          if (wb_ready_i) state_d = MUL_ISSUE_IDLE;
        end
        default: state_d = MUL_ISSUE_IDLE;
      endcase
    end

    // accept is only possible from IDLE or a draining WB, so one capture path serves both
    if (accept) begin
      funct3_d = id_funct3_i;
      op_a_d   = id_op_a_i;
      op_b_d   = id_op_b_i;
      rd_d     = id_rd_i;
      if (!funct3_is_mul(id_funct3_i) || zero_op) begin
        result_d = '0;
        state_d  = MUL_ISSUE_WB;
      end else begin
        state_d  = MUL_ISSUE_EXEC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= MUL_ISSUE_IDLE;
      funct3_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

endmodule

// File: tb/tb_cv32e41s_mult_issue.sv
// Self-checking bench for cv32e41s_mult_issue with a behavioural multiplier stub and arithmetic reference model.
module tb_cv32e41s_mult_issue;
  import cv32e41s_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kill_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [2:0]  id_funct3_i;
  logic [31:0] id_op_a_i, id_op_b_i;
  logic [4:0]  id_rd_i;
  logic        mul_valid_o;
  mul_opcode_e mul_operator_o;
  logic [1:0]  mul_signed_mode_o;
  logic [31:0] mul_op_a_o, mul_op_b_o;
  logic [31:0] mul_result_i;
  logic        mul_valid_i;
  logic        mul_ready_o;
  logic        mul_ready_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rd_o;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CV32E41S_MULT_ZERO_SHORTCUT_EN
  localparam int ZLAT_M = 1;
  localparam int ZLAT_H = 1;
`else
  localparam int ZLAT_M = 2;
  localparam int ZLAT_H = 5;
`endif

  cv32e41s_mult_issue #(.RD_W(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .kill_i            (kill_i),
    .id_valid_i        (id_valid_i),
    .id_ready_o        (id_ready_o),
    .id_funct3_i       (id_funct3_i),
    .id_op_a_i         (id_op_a_i),
    .id_op_b_i         (id_op_b_i),
    .id_rd_i           (id_rd_i),
    .mul_valid_o       (mul_valid_o),
    .mul_operator_o    (mul_operator_o),
    .mul_signed_mode_o (mul_signed_mode_o),
    .mul_op_a_o        (mul_op_a_o),
    .mul_op_b_o        (mul_op_b_o),
    .mul_result_i      (mul_result_i),
    .mul_valid_i       (mul_valid_i),
    .mul_ready_o       (mul_ready_o),
    .mul_ready_i       (mul_ready_i),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_result_o       (wb_result_o),
    .wb_rd_o           (wb_rd_o)
  );

  always #5 clk = ~clk;

  // Multiplier stub: MUL_M32 answers in its first valid cycle, MUL_H in its fourth.
  logic [1:0]  stub_cnt = 2'd0;
  logic [63:0] stub_pa, stub_pb, stub_prod;
  always_comb begin
    stub_pa      = {{32{mul_signed_mode_o[0] & mul_op_a_o[31]}}, mul_op_a_o};
    stub_pb      = {{32{mul_signed_mode_o[1] & mul_op_b_o[31]}}, mul_op_b_o};
    stub_prod    = stub_pa * stub_pb;
    mul_result_i = (mul_operator_o == MUL_M32) ? stub_prod[31:0] : stub_prod[63:32];
    mul_valid_i  = mul_valid_o && ((mul_operator_o == MUL_M32) || (stub_cnt == 2'd3));
    mul_ready_i  = !mul_valid_o || mul_valid_i;
  end
  always @(posedge clk) begin
    if (!mul_valid_o || mul_valid_i) stub_cnt <= 2'd0;
    else                             stub_cnt <= stub_cnt + 2'd1;
  end

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) return 1;
`ifdef CV32E41S_MULT_ZERO_SHORTCUT_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return (f3 == 3'd0) ? 2 : 5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_wb(input logic [31:0] a, input logic [31:0] b, output int lat,
                         output int mv_cycles, output bit stable,
                         output mul_opcode_e op_seen, output logic [1:0] mode_seen);
    lat = 0; mv_cycles = 0; stable = 1'b1; op_seen = MUL_M32; mode_seen = 2'b00;
    do begin
      @(negedge clk);
      lat++;
      if (mul_valid_o) begin
        mv_cycles++;
        op_seen   = mul_operator_o;
        mode_seen = mul_signed_mode_o;
        if (mul_op_a_o !== a || mul_op_b_o !== b) stable = 1'b0;
      end
    end while (!wb_valid_o && lat < 30);
  endtask

  // Starts and ends at a negedge with the DUT idle; bp = cycles of writeback backpressure.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                        input int exp_lat, input int bp);
    int lat, mv; bit stab; mul_opcode_e op; logic [1:0] mode;
    id_valid_i = 1'b1; id_funct3_i = f3; id_op_a_i = a; id_op_b_i = b; id_rd_i = rd;
    #1 check({name, ".id_ready"}, 32'(id_ready_o), 32'd1);
    @(posedge clk); #1 id_valid_i = 1'b0;
    wait_wb(a, b, lat, mv, stab, op, mode);
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    check({name, ".result"}, wb_result_o, exp_res);
    check({name, ".rd"}, 32'(wb_rd_o), 32'(rd));
    check({name, ".operands_stable"}, 32'(stab), 32'd1);
    if (f3[2]) check({name, ".no_mul_valid"}, 32'(mv), 32'd0);
    if (mv > 0) begin
      check({name, ".operator"}, 32'(op), 32'((f3 == 3'd0) ? MUL_M32 : MUL_H));
      check({name, ".mode"}, 32'(mode), (f3 == 3'd1) ? 32'd3 : (f3 == 3'd2) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check({name, ".bp_valid"}, 32'(wb_valid_o), 32'd1);
      check({name, ".bp_result"}, wb_result_o, exp_res);
    end
    wb_ready_i = 1'b1;
    @(posedge clk); #1 wb_ready_i = 1'b0;
    @(negedge clk);
    check({name, ".drained"}, 32'(wb_valid_o), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, mv; bit stab; mul_opcode_e op; logic [1:0] mode;
    logic [2:0] f3; logic [31:0] a, b; logic [4:0] rd;

    vecs[0] = '{"mul_7_m3",    3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2};
    vecs[1] = '{"mulh_min",    3'd1, 32'h80000000,   32'h80000000, 5'd1,  32'h40000000, 5};
    vecs[2] = '{"mulhsu_m1",   3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF, 5};
    vecs[3] = '{"mulhu_max",   3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 5};
    vecs[4] = '{"illegal_4",   3'd4, 32'd1234,       32'd5678,     5'd4,  32'd0,        1};
    vecs[5] = '{"illegal_7",   3'd7, 32'hDEADBEEF,   32'd9,        5'd31, 32'd0,        1};
    vecs[6] = '{"mulh_a_zero", 3'd1, 32'd0,          32'h12345678, 5'd6,  32'd0,        ZLAT_H};
    vecs[7] = '{"mul_b_zero",  3'd0, 32'hCAFEF00D,   32'd0,        5'd7,  32'd0,        ZLAT_M};

    rst_n = 1'b0; kill_i = 1'b0; id_valid_i = 1'b0; id_funct3_i = '0;
    id_op_a_i = '0; id_op_b_i = '0; id_rd_i = '0; wb_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.id_ready", 32'(id_ready_o), 32'd1);
    check("reset.mul_valid", 32'(mul_valid_o), 32'd0);
    check("reset.wb_valid", 32'(wb_valid_o), 32'd0);
    check("reset.wb_result", wb_result_o, 32'd0);
    check("reset.wb_rd", 32'(wb_rd_o), 32'd0);
    check("reset.op_a", mul_op_a_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].lat, 0);

    // Kill in the third EXEC cycle of a MULH, then a clean MUL.
    id_valid_i = 1'b1; id_funct3_i = 3'd1; id_op_a_i = 32'h1234; id_op_b_i = 32'h5678; id_rd_i = 5'd3;
    @(posedge clk); #1 id_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("kill.pre_mul_valid", 32'(mul_valid_o), 32'd1);
    kill_i = 1'b1;
    #1;
    check("kill.mul_valid", 32'(mul_valid_o), 32'd0);
    check("kill.id_ready", 32'(id_ready_o), 32'd0);
    check("kill.wb_valid", 32'(wb_valid_o), 32'd0);
    @(posedge clk); #1 kill_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("kill.after_wb_valid", 32'(wb_valid_o), 32'd0);
      check("kill.after_mul_valid", 32'(mul_valid_o), 32'd0);
    end
    check("kill.idle_ready", 32'(id_ready_o), 32'd1);
    run_op("kill.mul_3x4", 3'd0, 32'd3, 32'd4, 5'd8, 32'd12, 2, 0);

    // Backpressure then same-cycle accept of the next op.
    id_valid_i = 1'b1; id_funct3_i = 3'd0; id_op_a_i = 32'd5; id_op_b_i = 32'd6; id_rd_i = 5'd9;
    @(posedge clk); #1 id_valid_i = 1'b0;
    wait_wb(32'd5, 32'd6, lat, mv, stab, op, mode);
    check("bp.latency", 32'(lat), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp.hold_valid", 32'(wb_valid_o), 32'd1);
      check("bp.hold_result", wb_result_o, 32'd30);
      check("bp.hold_rd", 32'(wb_rd_o), 32'd9);
      check("bp.id_blocked", 32'(id_ready_o), 32'd0);
    end
    wb_ready_i = 1'b1; id_valid_i = 1'b1; id_funct3_i = 3'd0;
    id_op_a_i = 32'd2; id_op_b_i = 32'd9; id_rd_i = 5'd10;
    #1 check("b2b.id_ready", 32'(id_ready_o), 32'd1);
    @(posedge clk); #1 begin wb_ready_i = 1'b0; id_valid_i = 1'b0; end
    wait_wb(32'd2, 32'd9, lat, mv, stab, op, mode);
    check("b2b.latency", 32'(lat), 32'd2);
    check("b2b.result", wb_result_o, 32'd18);
    check("b2b.rd", 32'(wb_rd_o), 32'd10);
    wb_ready_i = 1'b1;
    @(posedge clk); #1 wb_ready_i = 1'b0;
    @(negedge clk);

    // Kill beats a simultaneous writeback accept.
    id_valid_i = 1'b1; id_funct3_i = 3'd0; id_op_a_i = 32'hA; id_op_b_i = 32'hB; id_rd_i = 5'd7;
    @(posedge clk); #1 id_valid_i = 1'b0;
    wait_wb(32'hA, 32'hB, lat, mv, stab, op, mode);
    check("killwb.pending", 32'(wb_valid_o), 32'd1);
    kill_i = 1'b1; wb_ready_i = 1'b1;
    #1 check("killwb.wb_valid", 32'(wb_valid_o), 32'd0);
    @(posedge clk); #1 begin kill_i = 1'b0; wb_ready_i = 1'b0; end
    @(negedge clk);
    check("killwb.after_valid", 32'(wb_valid_o), 32'd0);
    check("killwb.idle_ready", 32'(id_ready_o), 32'd1);

    // Reset in the middle of a MULH clears the registers.
    id_valid_i = 1'b1; id_funct3_i = 3'd3; id_op_a_i = 32'h777; id_op_b_i = 32'h999; id_rd_i = 5'd12;
    @(posedge clk); #1 id_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst.wb_valid", 32'(wb_valid_o), 32'd0);
    check("midrst.mul_valid", 32'(mul_valid_o), 32'd0);
    check("midrst.op_a", mul_op_a_o, 32'd0);
    check("midrst.wb_result", wb_result_o, 32'd0);
    check("midrst.id_ready", 32'(id_ready_o), 32'd1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rd = 5'($urandom);
      run_op($sformatf("rand%0d", i), f3, a, b, rd, ref_result(f3, a, b), ref_lat(f3, a, b),
             $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e41s_mult_issue.md
Name: cv32e41s_mult_issue

Overview:
Upstream issue/sequencing stage for the integer multiplier in EX. It accepts M-extension multiply instructions (MUL/MULH/MULHSU/MULHU) from ID over a valid/ready handshake and registers the operands and rd tag. It decodes funct3 into the multiplier operator and signed mode, and holds the multiplier inputs stable across its multicycle MULH sequence. The final result goes into a registered writeback slot with its own valid/ready handshake. kill_i flushes it at any time.

Parameters:
RD_W, 5, width of destination register tag.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
kill_i  in  1  flush: drop in-flight op and any pending result
id_valid_i  in  1  ID presents a multiply instruction
id_ready_o  out  1  block accepts the ID instruction this cycle
id_funct3_i  in  3  RV32M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU)
id_op_a_i  in  32  rs1 value
id_op_b_i  in  32  rs2 value
id_rd_i  in  RD_W  destination register
mul_valid_o  out  1  drives multiplier valid_i; low kills the multiplier
mul_operator_o  out  mul_opcode_e  MUL_M32 or MUL_H
mul_signed_mode_o  out  2  bit0: op_a signed; bit1: op_b signed
mul_op_a_o  out  32  registered operand A
mul_op_b_o  out  32  registered operand B
mul_result_i  in  32  multiplier result
mul_valid_i  in  1  multiplier result valid
mul_ready_o  out  1  drives multiplier ready_i
mul_ready_i  in  1  multiplier ready (op retired or idle)
wb_valid_o  out  1  result pending for writeback
wb_ready_i  in  1  writeback accepts
wb_result_o  out  32  registered result
wb_rd_o  out  RD_W  registered rd tag

Behaviour:
- Clock: one clock, clk. Reset: synchronous, active-low, rst_n. Reset is sampled only on the posedge of clk.
- Reset values: state IDLE; all operand, result and tag registers 0; id_ready_o=1; mul_valid_o=0; wb_valid_o=0.
- Decode (combinational on the registered funct3):
  - funct3 0: MUL_M32, signed mode 00.
  - funct3 1: MUL_H, signed mode 11.
  - funct3 2: MUL_H, signed mode 01.
  - funct3 3: MUL_H, signed mode 00.
  - funct3 4..7: illegal for this block.
- State IDLE:
  - id_ready_o=1.
  - On id_valid_i, capture funct3, operands and rd.
  - If funct3[2]=0, go to EXEC. If funct3[2]=1, load result 0 and go to WB.
- State EXEC:
  - mul_valid_o=1 and mul_ready_o=1; operands are held constant.
  - When mul_valid_i=1, capture mul_result_i into the wb register and go to WB.
- State WB:
  - wb_valid_o=1. wb_result_o and wb_rd_o are stable until accepted.
  - id_ready_o=wb_ready_i, allowing back-to-back issue.
  - On wb_ready_i with no new ID op, go to IDLE.
  - On wb_ready_i with id_valid_i in the same cycle, capture the new op and go to EXEC, or to WB if it is illegal.
- Latency, from ID accept at cycle T to wb_valid_o:
  - MUL: T+2.
  - MULH*: T+5, since the multiplier runs 4 cycles.
  - Illegal funct3: T+1.
- Kill:
  - kill_i=1 forces next state IDLE and clears wb_valid_o. mul_valid_o=0 that cycle, which resets the multiplier FSM and accumulator. id_ready_o=0 that cycle.
  - Kill wins over a simultaneous mul_valid_i or wb_ready_i; the result is discarded.
- Reset mid-operation: behaves as kill and also clears the registers.
- Invariant: mul_valid_o is never high outside EXEC.
- wb_valid_o must not drop without kill or wb_ready_i.

Optional Feature:
Macro: CV32E41S_MULT_ZERO_SHORTCUT_EN.
- Defined: on accept in IDLE or WB, if id_op_a_i==0 or id_op_b_i==0, load result 0 and go directly to WB. EXEC is skipped and latency becomes T+1 for all four ops.
- Undefined: every legal op goes through EXEC.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package cv32e41s_pkg gets:
  - mul_issue_state_e {MUL_ISSUE_IDLE, MUL_ISSUE_EXEC, MUL_ISSUE_WB}.
  - funct3 localparams FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU.
- mul_opcode_e is reused from the package.
- One combinational sub-module, cv32e41s_mult_decode: funct3 in; operator, signed_mode and illegal out.

Test Plan:
1. MUL: a=7, b=-3 (0xFFFFFFFD), rd=5, accepted T -> wb_valid_o at T+2, result 0xFFFFFFEB, rd 5; mul_operator_o=MUL_M32.
2. MULH: a=0x80000000, b=0x80000000 -> mode 11, result 0x40000000 at T+5; operands stable during EXEC.
3. MULHSU: a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU: same operands -> 0xFFFFFFFE.
4. Kill: kill_i in the third EXEC cycle of a MULH -> mul_valid_o=0 that cycle, no wb_valid_o, IDLE next; a following MUL 3*4 gives 12 at +2.
5. Backpressure: wb_ready_i low for 3 cycles -> result/rd held; when wb_ready_i rises with id_valid_i, the new op is accepted the same cycle and the next result appears 2 cycles later.
6. Illegal funct3=4 -> result 0 at T+1, mul_valid_o never asserted. With the macro, MULH a=0 -> 0 at T+1.
